mem_edit_ctrl: RTL and testbench

Parametrised front-panel memory editor: debounces four active-low push-buttons and drives the address, write data and write enable of a synchronous single-port RAM. Two keys step the address up and down. Two keys perform a read-modify-write increment or decrement of the addressed word. It sits between the board keys and the RAM. Compared with the single-width predecessor it adds debounce, configurable widths, a read-latency-aware read-modify-write FSM, a saturate/wrap mode and optional auto-repeat.

---
 rtl/mem_edit_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_mem_edit_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_edit_ctrl.sv
// mem_edit_ctrl: debounced front-panel RAM editor with address stepping and RMW inc/dec.
// Optional auto-repeat on held keys when MEM_EDIT_CTRL_AUTOREPEAT_EN is defined.
module mem_edit_ctrl #(
  parameter int AW           = 4,
  parameter int DW           = 8,
  parameter int RD_LAT       = 1,
  parameter int DB_CYCLES    = 16,
  parameter int WRAP         = 1,
  parameter int REPEAT_DELAY = 1000000,
  parameter int REPEAT_RATE  = 250000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    KEY,
  input  logic [DW-1:0] dout,
  output logic [AW-1:0] a,
  output logic [DW-1:0] din,
  output logic          we,
  output logic          busy
);

  localparam int CW  = $clog2(DB_CYCLES);
  localparam int WCW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    WRITE
  } state_t;

  logic [3:0]    s1_q, s2_q;
  logic [3:0]    db_q, dbd_q;
  logic [CW-1:0] dbc_q [4];
  logic [3:0]    pls_q, pls_d;
  logic [3:0]    rep_hit;

  state_t         state_q, state_d;
  logic [AW-1:0]  a_q, a_d;
  logic [DW-1:0]  din_q, din_d;
  logic           dir_q, dir_d;
  logic [WCW-1:0] wc_q, wc_d;
  logic [DW-1:0]  nxt;

  // two-flop synchroniser, idle level is high (released)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 4'hF;
      s2_q <= 4'hF;
    end else begin
      s1_q <= KEY;
      s2_q <= s1_q;
    end
  end

  // per-key debounce: flip after DB_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q <= '0;
      for (int i = 0; i < 4; i++) dbc_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (~s2_q[i] != db_q[i]) begin
          if (dbc_q[i] == CW'(DB_CYCLES - 1)) begin
            db_q[i]  <= ~s2_q[i];
            dbc_q[i] <= '0;
          end else begin
            dbc_q[i] <= dbc_q[i] + 1'b1;
          end
        end else begin
          dbc_q[i] <= '0;
        end
      end
    end
  end

`ifdef MEM_EDIT_CTRL_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

  logic [RW-1:0] rep_q [4];
  logic [3:0]    ph_q;

  // repeat hit: first after REPEAT_DELAY, then every REPEAT_RATE
  always_comb begin
    rep_hit = '0;
    for (int i = 0; i < 4; i++) begin
      if (db_q[i]) begin
        if (ph_q[i]) rep_hit[i] = (rep_q[i] == RW'(REPEAT_RATE - 1));
        else         rep_hit[i] = (rep_q[i] == RW'(REPEAT_DELAY));
      end
    end
  end

  // repeat counters, cleared whenever the key is released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q <= '0;
      for (int i = 0; i < 4; i++) rep_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!db_q[i]) begin
          rep_q[i] <= '0;
          ph_q[i]  <= 1'b0;
        end else if (rep_hit[i]) begin
          rep_q[i] <= '0;
          ph_q[i]  <= 1'b1;
        end else begin
          rep_q[i] <= rep_q[i] + 1'b1;
        end
      end
    end
  end
`else
  assign rep_hit = '0;
`endif

  assign pls_d = (db_q & ~dbd_q) | rep_hit;

  // press-edge detect into registered one-cycle action pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbd_q <= '0;
      pls_q <= '0;
    end else begin
      dbd_q <= db_q;
      pls_q <= pls_d;
    end
  end

  // new data value: wrap or saturate
  always_comb begin
    nxt = dout;
    if (dir_q) begin
      if (!(WRAP == 0 && dout == '1)) nxt = dout + 1'b1;
    end else begin
      if (!(WRAP == 0 && dout == '0)) nxt = dout - 1'b1;
    end
  end

  // FSM next state, address stepping and write data
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    din_d   = din_q;
    dir_d   = dir_q;
    wc_d    = wc_q;
    unique case (state_q)
      IDLE: begin
        priority case (1'b1)
          pls_q[3]: a_d = a_q + 1'b1;
          pls_q[2]: a_d = a_q - 1'b1;
          pls_q[1]: begin
            state_d = WAIT;
            dir_d   = 1'b1;
            wc_d    = '0;
          end
          pls_q[0]: begin
            state_d = WAIT;
            dir_d   = 1'b0;
            wc_d    = '0;
          end
          default: ;
        endcase
      end
      WAIT: begin
        if (wc_q == WCW'(RD_LAT)) begin
          state_d = WRITE;
          din_d   = nxt;
        end else begin
          wc_d = wc_q + 1'b1;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      din_q   <= '0;
      dir_q   <= 1'b0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      din_q   <= din_d;
      dir_q   <= dir_d;
      wc_q    <= wc_d;
    end
  end

  assign a    = a_q;
  assign din  = din_q;
  assign we   = (state_q == WRITE);
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_edit_ctrl.sv
// tb_mem_edit_ctrl: directed bench, one wrapping and one saturating instance
// sharing keys, each with its own RD_LAT=2 RAM model.
module tb_mem_edit_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] KEY;

  logic [3:0] a_w, a_s;
  logic [7:0] din_w, din_s, dout_w, dout_s;
  logic       we_w, we_s, busy_w, busy_s;

  logic [7:0] mem_w [16];
  logic [7:0] mem_s [16];
  logic [7:0] r1_w, r1_s;
  logic       pk_en = 1'b0;
  logic [3:0] pk_a  = '0;
  logic [7:0] pk_d  = '0;

  int checks   = 0;
  int failures = 0;
  int wec_w    = 0;
  int wec_s    = 0;
  int busyc    = 0;

  always #5 clk = ~clk;

  mem_edit_ctrl #(
    .AW(4), .DW(8), .RD_LAT(2), .DB_CYCLES(4), .WRAP(1),
    .REPEAT_DELAY(20), .REPEAT_RATE(10)
  ) u_wrap (
    .clk(clk), .rst_n(rst_n), .KEY(KEY), .dout(dout_w),
    .a(a_w), .din(din_w), .we(we_w), .busy(busy_w)
  );

  mem_edit_ctrl #(
    .AW(4), .DW(8), .RD_LAT(2), .DB_CYCLES(4), .WRAP(0),
    .REPEAT_DELAY(20), .REPEAT_RATE(10)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .KEY(KEY), .dout(dout_s),
    .a(a_s), .din(din_s), .we(we_s), .busy(busy_s)
  );

  always @(posedge clk) begin
    r1_w   <= mem_w[a_w];
    dout_w <= r1_w;
    r1_s   <= mem_s[a_s];
    dout_s <= r1_s;
    if (pk_en) begin
      mem_w[pk_a] <= pk_d;
      mem_s[pk_a] <= pk_d;
    end else begin
      if (we_w) mem_w[a_w] <= din_w;
      if (we_s) mem_s[a_s] <= din_s;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (we_w)   wec_w = wec_w + 1;
      if (we_s)   wec_s = wec_s + 1;
      if (busy_w) busyc = busyc + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [3:0] ad, input logic [7:0] d);
    @(negedge clk);
    pk_a  = ad;
    pk_d  = d;
    pk_en = 1'b1;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  task automatic press(input logic [3:0] mask, input int n);
    @(negedge clk);
    KEY = ~mask;
    repeat (n) @(negedge clk);
    KEY = 4'hF;
    repeat (16) @(negedge clk);
  endtask

  initial begin
    int w0, s0, b0;
    int ab;
    bit seen;
    rst_n = 1'b0;
    KEY   = 4'hF;
    for (int i = 0; i < 16; i++) begin
      mem_w[i] = '0;
      mem_s[i] = '0;
    end
    repeat (4) @(negedge clk);
    check("rst_we", {31'd0, we_w}, 32'd0);
    check("rst_busy", {31'd0, busy_w}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_state", {a_w, din_w, we_w, busy_w, a_s, din_s, we_s, busy_s},
            32'd0);
    end

    for (int i = 0; i < 16; i++) begin
      press(4'b1000, 10);
      check("addr_up", {28'd0, a_w}, 32'((i + 1) % 16));
    end
    press(4'b0100, 10);
    check("addr_dn_wrap", {28'd0, a_w}, 32'd15);
    for (int i = 0; i < 6; i++) press(4'b1000, 10);
    check("addr_5", {28'd0, a_w}, 32'd5);
    check("addr_5_sat", {28'd0, a_s}, 32'd5);

    poke(4'd5, 8'hFF);
    w0 = wec_w; s0 = wec_s; b0 = busyc;
    press(4'b0010, 10);
    check("inc_ff_din_wrap", {24'd0, din_w}, 32'h00);
    check("inc_ff_din_sat", {24'd0, din_s}, 32'hFF);
    check("inc_we_wrap", 32'(wec_w - w0), 32'd1);
    check("inc_we_sat", 32'(wec_s - s0), 32'd1);
    check("inc_busy_len", 32'(busyc - b0), 32'd4);
    check("inc_mem_wrap", {24'd0, mem_w[5]}, 32'h00);
    check("inc_mem_sat", {24'd0, mem_s[5]}, 32'hFF);
    check("inc_addr_hold", {28'd0, a_w}, 32'd5);

    press(4'b0100, 10);
    press(4'b0100, 10);
    check("addr_3", {28'd0, a_w}, 32'd3);
    poke(4'd3, 8'h00);
    w0 = wec_w; s0 = wec_s;
    press(4'b0001, 10);
    check("dec_00_din_wrap", {24'd0, din_w}, 32'hFF);
    check("dec_00_din_sat", {24'd0, din_s}, 32'h00);
    check("dec_we_sat", 32'(wec_s - s0), 32'd1);
    check("dec_mem_wrap", {24'd0, mem_w[3]}, 32'hFF);

    w0 = wec_w;
    press(4'b0010, 3);
    check("glitch_no_we", 32'(wec_w - w0), 32'd0);
    check("glitch_din", {24'd0, din_w}, 32'hFF);

    w0 = wec_w;
    press(4'b1010, 10);
    check("prio_addr", {28'd0, a_w}, 32'd4);
    check("prio_no_we", 32'(wec_w - w0), 32'd0);

    poke(4'd4, 8'h10);
    w0 = wec_w;
    @(negedge clk);
    KEY = 4'b1101;
    repeat (2) @(negedge clk);
    KEY = 4'b1100;
    repeat (8) @(negedge clk);
    KEY = 4'hF;
    repeat (20) @(negedge clk);
    check("busy_discard_we", 32'(wec_w - w0), 32'd1);
    check("busy_discard_mem", {24'd0, mem_w[4]}, 32'h11);
    check("busy_discard_din", {24'd0, din_s}, 32'h11);

    ab = int'(a_w);
    press(4'b1000, 68);
`ifdef MEM_EDIT_CTRL_AUTOREPEAT_EN
    check("repeat_adv", {28'd0, a_w}, 32'((ab + 6) % 16));
`else
    check("repeat_adv", {28'd0, a_w}, 32'((ab + 1) % 16));
`endif

    seen = 1'b0;
    @(negedge clk);
    KEY = 4'b1101;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (we_w) begin
        seen = 1'b1;
        break;
      end
    end
    check("mid_write_reached", {31'd0, seen}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_we", {31'd0, we_w}, 32'd0);
    check("async_rst_busy", {31'd0, busy_s}, 32'd0);
    check("async_rst_a", {28'd0, a_w}, 32'd0);
    KEY = 4'hF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
